apb_master: RTL and testbench

APB requester for the peripheral bus. It converts single-beat commands from a local valid/ready command port into APB SETUP/ACCESS transfers on the `pclk` domain, and returns read data and an error flag on a one-cycle response strobe. It sits directly upstream of the APB slaves (8-bit address, 16-bit data) and is their only driver of `psel`, `penable`, `paddr`, `pwrite` and `pwdata`.

---
 rtl/apb_master.sv | 162 ++++++++++++++++
 tb/tb_apb_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Single-beat APB requester. A command accepted on the local valid/ready port
// becomes one APB SETUP + ACCESS transfer. The result comes back on a one-cycle
// response strobe, together with read data and a timeout error flag.
//
// Ports
//   pclk, rst                   clock and synchronous active-high reset
//   cmd_valid / cmd_ready       command handshake (cmd_ready = IDLE decode)
//   cmd_write, cmd_addr,        command fields, latched on handshake
//   cmd_wdata
//   rsp_valid                   one-cycle completion strobe (no backpressure)
//   rsp_rdata, rsp_err          read data (0 for writes/errors), timeout flag
//   psel, penable, paddr,       APB requester outputs, all registered
//   pwrite, pwdata
//   pready, prdata              APB completer inputs, used only in ACCESS
// -----------------------------------------------------------------------------
module apb_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int MIN_ACC = 1,   // 1..15
   parameter int TIMEOUT = 16   // 1..255, 0 disables
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   // The ACCESS cycle count is compared in 9 bits so that acc_cnt+1 cannot wrap.
   localparam logic [8:0] MIN_ACC_W  = 9'(MIN_ACC);
   localparam logic [8:0] TIMEOUT_W  = 9'(TIMEOUT);
   localparam bit         TIMEOUT_EN = (TIMEOUT != 0);

   logic [1:0]        state_q,     state_d;
   logic [7:0]        acc_cnt_q,   acc_cnt_d;
   logic              psel_q,      psel_d;
   logic              penable_q,   penable_d;
   logic [ADDR_W-1:0] paddr_q,     paddr_d;
   logic              pwrite_q,    pwrite_d;
   logic [DATA_W-1:0] pwdata_q,    pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;

   // Number of ACCESS cycles including the current one.
   logic [8:0] acc_num;
   logic       done;
   logic       tout;

   assign acc_num = {1'b0, acc_cnt_q} + 9'd1;
   // Completion has priority over the timeout when both hit in the same cycle.
   assign done    = pready && (acc_num >= MIN_ACC_W);
   assign tout    = !done && TIMEOUT_EN && (acc_num == TIMEOUT_W);

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      acc_cnt_d   = acc_cnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_wdata;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            acc_cnt_d = 8'd0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            acc_cnt_d = (acc_cnt_q == 8'hFF) ? acc_cnt_q : acc_cnt_q + 8'd1;
            if (done || tout) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = tout;
               rsp_rdata_d = (pwrite_q || tout) ? '0 : prdata;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_cnt_q   <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_cnt_q   <= acc_cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign paddr     = paddr_q;
   assign pwrite    = pwrite_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//
// Two instances: index 0 uses the defaults (MIN_ACC=1, TIMEOUT=16), index 1
// uses MIN_ACC=2, TIMEOUT=4. Each transfer is described by a pready pattern per
// ACCESS cycle; the reference model derives the ACCESS length, error flag and
// response data from that pattern alone.
// -----------------------------------------------------------------------------
module tb_apb_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid [2];
   logic        cmd_ready [2];
   logic        cmd_write [2];
   logic [7:0]  cmd_addr  [2];
   logic [15:0] cmd_wdata [2];
   logic        rsp_valid [2];
   logic [15:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic        psel      [2];
   logic        penable   [2];
   logic [7:0]  paddr     [2];
   logic        pwrite    [2];
   logic [15:0] pwdata    [2];
   logic        pready    [2];
   logic [15:0] prdata    [2];

   int checks = 0;
   int errors = 0;

   // pready per ACCESS cycle (index k-1 for the k-th cycle) and prdata per
   // cycle after the handshake (index n for cycle E+n).
   bit          pr_pat [0:255];
   logic [15:0] pd_pat [0:299];

   always #5 clk = ~clk;

   apb_master u_dut0 (
      .pclk(clk), .rst(rst),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
      .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
      .psel(psel[0]), .penable(penable[0]), .paddr(paddr[0]), .pwrite(pwrite[0]),
      .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0])
   );

   apb_master #(.MIN_ACC(2), .TIMEOUT(4)) u_dut1 (
      .pclk(clk), .rst(rst),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
      .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
      .psel(psel[1]), .penable(penable[1]), .paddr(paddr[1]), .pwrite(pwrite[1]),
      .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: the transfer ends in the first ACCESS cycle k where pready
   // is high and k >= MIN_ACC; otherwise it is aborted at k == TIMEOUT.
   task automatic model(input int d, output int len, output bit err);
      int min_acc;
      int tmo;
      min_acc = (d == 0) ? 1 : 2;
      tmo     = (d == 0) ? 16 : 4;
      len = 255;
      err = 1'b0;
      for (int k = 1; k <= 255; k++) begin
         if (pr_pat[k-1] && k >= min_acc) begin
            len = k; err = 1'b0; break;
         end
         if (tmo != 0 && k == tmo) begin
            len = k; err = 1'b1; break;
         end
      end
   endtask

   task automatic check_reset_outputs(input int d, input string tag);
      check({tag, " ctl"}, {28'd0, psel[d], penable[d], cmd_ready[d], rsp_valid[d]}, 32'h2);
      check({tag, " bus"}, {7'd0, paddr[d], pwrite[d], pwdata[d]}, 32'h0);
      check({tag, " rsp"}, {15'd0, rsp_err[d], rsp_rdata[d]}, 32'h0);
   endtask

   // Called at a negedge with the DUT in IDLE. Issues one command and checks
   // every cycle up to and including the response cycle.
   task automatic do_xfer(input int d, input bit wr, input logic [7:0] a,
                          input logic [15:0] wd, input bit hold, input int len,
                          input bit exp_err, input logic [15:0] exp_rd, input string tag);
      logic [3:0] exp_ph;
      cmd_valid[d] = 1'b1;
      cmd_write[d] = wr;
      cmd_addr[d]  = a;
      cmd_wdata[d] = wd;
      prdata[d]    = pd_pat[0];
      check($sformatf("%s ready", tag), {31'd0, cmd_ready[d]}, 32'd1);
      @(posedge clk);
      for (int n = 1; n <= len + 2; n++) begin
         @(negedge clk);
         // {psel, penable, cmd_ready, rsp_valid}
         if (n == 1)            exp_ph = 4'b1000;
         else if (n <= len + 1) exp_ph = 4'b1100;
         else                   exp_ph = 4'b0011;
         check($sformatf("%s n=%0d phase", tag, n),
               {28'd0, psel[d], penable[d], cmd_ready[d], rsp_valid[d]}, {28'd0, exp_ph});
         check($sformatf("%s n=%0d bus", tag, n),
               {7'd0, paddr[d], pwrite[d], pwdata[d]}, {7'd0, a, wr, wd});
         if (n == len + 2)
            check($sformatf("%s rsp", tag), {15'd0, rsp_err[d], rsp_rdata[d]},
                  {15'd0, exp_err, exp_rd});
         if (n == 1 && !hold) cmd_valid[d] = 1'b0;
         pready[d] = (n >= 2 && n - 2 < len) ? pr_pat[n-2] : 1'($urandom);
         prdata[d] = pd_pat[n];
      end
      if (!hold) begin
         @(negedge clk);
         check($sformatf("%s strobe", tag), {30'd0, rsp_valid[d], psel[d]}, 32'd0);
      end
   endtask

   typedef struct {
      int          d;
      bit          wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          nwait;   // low-pready ACCESS cycles before pready goes high
      int          exp_len;
      bit          exp_err;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int          len;
      bit          err;
      int          d;
      bit          wr;
      int          pct;
      int          mode;
      logic [15:0] exp_rd;
      logic [15:0] b2b_data [4];
      int          stray;

      vecs[0] = '{0, 1'b1, 8'h12, 16'hBEEF, 16'h1111,   0,  1, 1'b0, 16'h0000};
      vecs[1] = '{0, 1'b0, 8'h34, 16'h0000, 16'hA5A5,   3,  4, 1'b0, 16'hA5A5};
      vecs[2] = '{1, 1'b0, 8'h56, 16'h0000, 16'h1234,   0,  2, 1'b0, 16'h1234};
      vecs[3] = '{1, 1'b1, 8'h78, 16'hCAFE, 16'h7777, 255,  4, 1'b1, 16'h0000};
      vecs[4] = '{1, 1'b0, 8'h79, 16'h0000, 16'h6666, 255,  4, 1'b1, 16'h0000};
      vecs[5] = '{0, 1'b0, 8'hFE, 16'h0000, 16'h5A5A,  15, 16, 1'b0, 16'h5A5A};
      vecs[6] = '{0, 1'b1, 8'h01, 16'h8001, 16'h2222,  16, 16, 1'b1, 16'h0000};
      vecs[7] = '{1, 1'b0, 8'hAB, 16'h0000, 16'h3C3C,   3,  4, 1'b0, 16'h3C3C};
      vecs[8] = '{1, 1'b0, 8'hCD, 16'h0000, 16'h4242,   1,  2, 1'b0, 16'h4242};

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0; cmd_addr[i] = '0;
         cmd_wdata[i] = '0;   pready[i]    = 1'b0; prdata[i]   = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_outputs(0, "reset d0");
      check_reset_outputs(1, "reset d1");

      // Directed vectors.
      foreach (vecs[i]) begin
         for (int k = 0; k < 256; k++) pr_pat[k] = (k >= vecs[i].nwait);
         for (int n = 0; n < 300; n++) pd_pat[n] = vecs[i].rdata;
         do_xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0,
                 vecs[i].exp_len, vecs[i].exp_err, vecs[i].exp_rd, $sformatf("vec%0d", i));
      end

      // Back-to-back: cmd_valid stays high across four reads.
      b2b_data[0] = 16'h0F01; b2b_data[1] = 16'h0F02;
      b2b_data[2] = 16'h0F03; b2b_data[3] = 16'h0F04;
      for (int k = 0; k < 256; k++) pr_pat[k] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int n = 0; n < 300; n++) pd_pat[n] = b2b_data[i];
         do_xfer(0, 1'b0, 8'h40 + 8'(i), 16'h0000, (i < 3), 1, 1'b0, b2b_data[i],
                 $sformatf("b2b%0d", i));
      end

      // Reset during ACCESS drops the transfer.
      cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 8'h9A; cmd_wdata[0] = 16'h5555;
      pready[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      @(negedge clk);
      check("rst access", {30'd0, psel[0], penable[0]}, 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs(0, "midrst");
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid[0] || psel[0]) stray++;
      end
      check("midrst no rsp", stray, 0);
      for (int n = 0; n < 300; n++) pd_pat[n] = 16'h7E7E;
      do_xfer(0, 1'b0, 8'h9B, 16'h0000, 1'b0, 1, 1'b0, 16'h7E7E, "after rst");

      // Randomised transfers against the reference model.
      for (int i = 0; i < 40; i++) begin
         d    = int'($urandom_range(0, 1));
         wr   = 1'($urandom);
         mode = int'($urandom_range(0, 3));
         pct  = (mode == 0) ? 0 : (mode == 1) ? 30 : (mode == 2) ? 70 : 100;
         for (int k = 0; k < 256; k++) pr_pat[k] = ($urandom_range(0, 99) < pct);
         for (int n = 0; n < 300; n++) pd_pat[n] = 16'($urandom);
         model(d, len, err);
         exp_rd = (wr || err) ? 16'h0000 : pd_pat[len + 1];
         do_xfer(d, wr, 8'($urandom), 16'($urandom), 1'b0, len, err, exp_rd,
                 $sformatf("rnd%0d", i));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
